// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg -- constants shared by the CPU front end.
//   INST_W     : instruction / PC word width
//   NOP_INST   : value shown on idle instruction outputs
//   pcsrc_e    : next-PC select encodings. Any value other than PCSRC_PC4
//                means a taken branch or jump, which flushes the instruction
//                queue.
// ----------------------------------------------------------------------------
package cpu_pkg;

  localparam int unsigned INST_W = 32;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    PCSRC_PC4    = 2'b00,
    PCSRC_BRANCH = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pcsrc_e;

  // True when the selected next PC leaves the sequential stream.
  function automatic logic pcsrc_redirects(input pcsrc_e src);
    return src != PCSRC_PC4;
  endfunction

endpackage

// File: rtl/queue_mem.sv
// ----------------------------------------------------------------------------
// queue_mem -- DEPTH x (2*INST_W) register array for the instruction queue.
// One synchronous write port, one asynchronous read port. Contents are not
// reset; validity is tracked by the owner of the pointers.
// Ports:
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data {pc, inst}
//   raddr : read address
//   rdata : read data, combinational from raddr
// ----------------------------------------------------------------------------
module queue_mem
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned DW   = 2 * INST_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/inst_queue.sv
// ----------------------------------------------------------------------------
// inst_queue -- FIFO between fetch and decode.
// Parameter DEPTH (power of two, >= 2) sets the number of entries.
// Optional feature macro: INST_QUEUE_BYPASS_EN. When defined, an instruction
// arriving at an empty queue is shown to decode in the same cycle and, if
// decode takes it, never written to storage.
// Ports:
//   Clk, Clr            : clock, asynchronous active-high reset
//   In_valid/In_ready   : fetch handshake; In_inst, In_pc are the payload
//   Out_valid/Out_ready : decode handshake; Out_inst, Out_pc are the payload
//   Flush               : taken branch/jump, discards every entry
//   Count               : occupancy, 0..DEPTH
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1 and Flush is 0. In_ready depends only on registered occupancy (never
// on Out_ready), so a full queue refuses a push even when a pop happens in the
// same cycle. Idle outputs (Out_valid=0) carry NOP, never stale data.
// ----------------------------------------------------------------------------
module inst_queue
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              In_valid,
  output logic              In_ready,
  input  logic [INST_W-1:0] In_inst,
  input  logic [INST_W-1:0] In_pc,
  output logic              Out_valid,
  input  logic              Out_ready,
  output logic [INST_W-1:0] Out_inst,
  output logic [INST_W-1:0] Out_pc,
  input  logic              Flush,
  output logic [CW-1:0]     Count
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic              empty;
  logic              bypass_act;
  logic              push;
  logic              pop;
  logic              wr_en;
  logic              rd_en;
  logic [2*INST_W-1:0] rdata;

  assign empty    = (count_q == '0);
  assign In_ready = (count_q != FULL);

`ifdef INST_QUEUE_BYPASS_EN
  // Clr is included so outputs read idle while reset is held even if fetch
  // is still presenting an instruction.
  assign bypass_act = empty && In_valid && !Flush && !Clr;
`else
  assign bypass_act = 1'b0;
`endif

  assign Out_valid = !empty || bypass_act;

  assign push = In_valid && In_ready && !Flush;
  assign pop  = Out_valid && Out_ready && !Flush;

  // A bypassed entry consumed in the same cycle never touches storage; an
  // entry popped from storage needs a non-empty queue.
  assign wr_en = push && !(bypass_act && Out_ready);
  assign rd_en = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (Flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are AW bits wide, so increments wrap modulo DEPTH.
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  queue_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (Clk),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata ({In_pc, In_inst}),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  always_comb begin
    Out_inst = NOP_INST;
    Out_pc   = NOP_INST;
    if (bypass_act) begin
      Out_inst = In_inst;
      Out_pc   = In_pc;
    end else if (Out_valid) begin
      Out_inst = rdata[INST_W-1:0];
      Out_pc   = rdata[2*INST_W-1:INST_W];
    end
  end

  assign Count = count_q;

endmodule

// File: tb/tb_inst_queue.sv
module tb_inst_queue;

  localparam int DEPTH = 4;
`ifdef INST_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic        Clk = 1'b0;
  logic        Clr;
  logic        In_valid, In_ready, Out_valid, Out_ready, Flush;
  logic [31:0] In_inst, In_pc, Out_inst, Out_pc;
  logic [2:0]  Count;

  always #5 Clk = ~Clk;

  inst_queue #(.DEPTH(DEPTH)) dut (
    .Clk       (Clk),
    .Clr       (Clr),
    .In_valid  (In_valid),
    .In_ready  (In_ready),
    .In_inst   (In_inst),
    .In_pc     (In_pc),
    .Out_valid (Out_valid),
    .Out_ready (Out_ready),
    .Out_inst  (Out_inst),
    .Out_pc    (Out_pc),
    .Flush     (Flush),
    .Count     (Count)
  );

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    In_valid  = v;
    In_inst   = inst;
    In_pc     = pc;
    Out_ready = ordy;
    Flush     = fl;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  // Advance one edge; sample point is 1 ns after the rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    Clr = 1'b1;
    idle();
    #12;
    checks++; if (Count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", Count); end
    checks++; if (Out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", Out_valid); end
    checks++; if (In_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", In_ready); end
    checks++; if (Out_inst !== 32'h0 || Out_pc !== 32'h0) begin failures++;
      $display("FAIL reset_out_data got=%h/%h exp=0/0", Out_inst, Out_pc); end
    @(negedge Clk);
    Clr = 1'b0;
    tick();
  endtask

  task automatic test_single();
    drive(1'b1, 32'h2008_0005, 32'h0000_0004, 1'b0, 1'b0);
    #1;
    checks++; if (Out_valid !== BYP) begin failures++; $display("FAIL single_pre_valid got=%b exp=%b", Out_valid, BYP); end
    tick();
    idle();
    #1;
    checks++; if (Out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", Out_valid); end
    checks++; if (Out_inst !== 32'h2008_0005) begin failures++; $display("FAIL single_inst got=%h exp=20080005", Out_inst); end
    checks++; if (Out_pc !== 32'h0000_0004) begin failures++; $display("FAIL single_pc got=%h exp=00000004", Out_pc); end
    checks++; if (Count !== 3'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", Count); end
    Out_ready = 1'b1;
    tick();
    idle();
    #1;
    checks++; if (Count !== 3'd0) begin failures++; $display("FAIL single_pop_count got=%0d exp=0", Count); end
    checks++; if (Out_valid !== 1'b0 || Out_inst !== 32'h0) begin failures++;
      $display("FAIL single_pop_out got=%b/%h exp=0/00000000", Out_valid, Out_inst); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 32'(i), 32'h100 + 32'(i), 1'b0, 1'b0);
      tick();
    end
    checks++; if (Count !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d exp=4", Count); end
    checks++; if (In_ready !== 1'b0) begin failures++; $display("FAIL fill_in_ready got=%b exp=0", In_ready); end
    drive(1'b1, 32'd5, 32'h105, 1'b0, 1'b0);
    tick();
    checks++; if (Count !== 3'd4) begin failures++; $display("FAIL fill_refuse_count got=%0d exp=4", Count); end
    // Full plus pop in the same cycle: push still refused.
    drive(1'b1, 32'd5, 32'h105, 1'b1, 1'b0);
    #1;
    checks++; if (Out_inst !== 32'd1 || Out_pc !== 32'h101) begin failures++;
      $display("FAIL fill_head1 got=%h/%h exp=00000001/00000101", Out_inst, Out_pc); end
    tick();
    checks++; if (Count !== 3'd3) begin failures++; $display("FAIL fill_full_pop_count got=%0d exp=3", Count); end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    for (int k = 2; k <= 4; k++) begin
      #1;
      checks++; if (Out_inst !== 32'(k)) begin failures++; $display("FAIL fill_order got=%h exp=%h", Out_inst, 32'(k)); end
      tick();
    end
    idle();
    #1;
    checks++; if (Count !== 3'd0 || Out_valid !== 1'b0) begin failures++;
      $display("FAIL fill_drain got=%0d/%b exp=0/0", Count, Out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    exp_q.delete();
    for (int n = 0; n < 2; n++) begin
      v = 32'hA000_0000 + 32'(n);
      drive(1'b1, v, 32'h1000 + 32'(4 * n), 1'b0, 1'b0);
      exp_q.push_back(v);
      tick();
    end
    checks++; if (Count !== 3'd2) begin failures++; $display("FAIL b2b_start_count got=%0d exp=2", Count); end
    for (int n = 2; n < 12; n++) begin
      v = 32'hA000_0000 + 32'(n);
      drive(1'b1, v, 32'h1000 + 32'(4 * n), 1'b1, 1'b0);
      #1;
      checks++; if (Out_inst !== exp_q[0]) begin failures++; $display("FAIL b2b_order got=%h exp=%h", Out_inst, exp_q[0]); end
      checks++; if (Out_pc !== 32'h1000 + ((exp_q[0] - 32'hA000_0000) << 2)) begin failures++;
        $display("FAIL b2b_pc got=%h exp=%h", Out_pc, 32'h1000 + ((exp_q[0] - 32'hA000_0000) << 2)); end
      tick();
      void'(exp_q.pop_front());
      exp_q.push_back(v);
      checks++; if (Count !== 3'd2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", Count); end
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    while (exp_q.size() > 0) begin
      #1;
      checks++; if (Out_inst !== exp_q[0]) begin failures++; $display("FAIL b2b_drain got=%h exp=%h", Out_inst, exp_q[0]); end
      tick();
      void'(exp_q.pop_front());
    end
    idle();
    #1;
    checks++; if (Count !== 3'd0) begin failures++; $display("FAIL b2b_end_count got=%0d exp=0", Count); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hF0 + 32'(i), 32'h200 + 32'(i), 1'b0, 1'b0);
      tick();
    end
    checks++; if (Count !== 3'd3) begin failures++; $display("FAIL flush_pre_count got=%0d exp=3", Count); end
    drive(1'b1, 32'hDEAD_BEEF, 32'h0BAD_0000, 1'b1, 1'b1);
    tick();
    idle();
    #1;
    checks++; if (Count !== 3'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", Count); end
    checks++; if (Out_valid !== 1'b0 || Out_inst !== 32'h0) begin failures++;
      $display("FAIL flush_out got=%b/%h exp=0/00000000", Out_valid, Out_inst); end
    drive(1'b1, 32'h0000_1234, 32'h0000_0300, 1'b0, 1'b0);
    tick();
    idle();
    #1;
    checks++; if (Out_inst !== 32'h0000_1234 || Count !== 3'd1) begin failures++;
      $display("FAIL flush_next got=%h/%0d exp=00001234/1", Out_inst, Count); end
    Out_ready = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_clr_mid();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h77 + 32'(i), 32'h400 + 32'(i), 1'b0, 1'b0);
      tick();
    end
    idle();
    checks++; if (Count !== 3'd2) begin failures++; $display("FAIL clr_pre_count got=%0d exp=2", Count); end
    Clr = 1'b1;
    #1;
    checks++; if (Count !== 3'd0 || Out_valid !== 1'b0) begin failures++;
      $display("FAIL clr_async got=%0d/%b exp=0/0", Count, Out_valid); end
    checks++; if (Out_inst !== 32'h0 || Out_pc !== 32'h0 || In_ready !== 1'b1) begin failures++;
      $display("FAIL clr_async_out got=%h/%h/%b exp=0/0/1", Out_inst, Out_pc, In_ready); end
    tick();
    Clr = 1'b0;
    drive(1'b1, 32'h0000_5555, 32'h0000_0500, 1'b0, 1'b0);
    tick();
    idle();
    #1;
    checks++; if (Count !== 3'd1 || Out_inst !== 32'h0000_5555) begin failures++;
      $display("FAIL clr_first_push got=%0d/%h exp=1/00005555", Count, Out_inst); end
    Out_ready = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_bypass();
    drive(1'b1, 32'h2008_0005, 32'h0000_0004, 1'b1, 1'b0);
    #1;
    checks++; if (Out_valid !== BYP) begin failures++; $display("FAIL bypass_valid got=%b exp=%b", Out_valid, BYP); end
    checks++; if (Out_inst !== (BYP ? 32'h2008_0005 : 32'h0)) begin failures++;
      $display("FAIL bypass_inst got=%h exp=%h", Out_inst, (BYP ? 32'h2008_0005 : 32'h0)); end
    tick();
    idle();
    #1;
    checks++; if (Count !== (BYP ? 3'd0 : 3'd1)) begin failures++;
      $display("FAIL bypass_count got=%0d exp=%0d", Count, (BYP ? 0 : 1)); end
    Out_ready = 1'b1;
    tick();
    idle();
    #1;
    checks++; if (Count !== 3'd0) begin failures++; $display("FAIL bypass_end_count got=%0d exp=0", Count); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_flush();
    test_clr_mid();
    test_bypass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
